// File: rtl/adder_op_queue.sv
// Issue stage in front of the fixed-latency adder: buffers requests, issues one per
// cycle under a credit limit, and returns results in order with their mode echoed.
module adder_op_queue #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_f_i,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  output logic [1:0]       f_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  input  logic [WIDTH-1:0] y_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_y_o,
  output logic [1:0]       rsp_f_o,
  output logic             busy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [1:0]       reqFMem [DEPTH];
  logic [WIDTH-1:0] reqAMem [DEPTH];
  logic [WIDTH-1:0] reqBMem [DEPTH];
  logic [1:0]       resFMem [DEPTH];
  logic [WIDTH-1:0] resYMem [DEPTH];

  ptr_t reqWrPtr_q, reqWrPtr_d, reqRdPtr_q, reqRdPtr_d;
  ptr_t resWrPtr_q, resWrPtr_d, resRdPtr_q, resRdPtr_d;
  cnt_t reqCount_q, reqCount_d, inflight_q, inflight_d, resCount_q, resCount_d;
  logic [LAT:0]      issueSr_q, issueSr_d;
  logic [LAT:0][1:0] modeSr_q, modeSr_d;
  logic [1:0]        f_q, f_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;

  logic        enq, issue, capture, pop;
  logic [CW:0] occupancy;

  assign req_ready_o = (reqCount_q != cnt_t'(DEPTH));
  assign rsp_valid_o = (resCount_q != '0);
  assign busy_o      = (reqCount_q != '0) || (inflight_q != '0) || (resCount_q != '0);
  assign rsp_y_o     = resYMem[resRdPtr_q];
  assign rsp_f_o     = resFMem[resRdPtr_q];
  assign f_o         = f_q;
  assign a_o         = a_q;
  assign b_o         = b_q;

  // A result slot is reserved for every issued op, so captures can never overflow.
  assign occupancy = {1'b0, inflight_q} + {1'b0, resCount_q};
  assign enq       = req_valid_i && req_ready_o;
  assign issue     = (reqCount_q != '0) && (occupancy < (CW+1)'(DEPTH));
  assign capture   = issueSr_q[LAT];
  assign pop       = rsp_valid_o && rsp_ready_i;

  always_comb begin
    reqWrPtr_d = reqWrPtr_q;
    reqRdPtr_d = reqRdPtr_q;
    resWrPtr_d = resWrPtr_q;
    resRdPtr_d = resRdPtr_q;
    f_d        = f_q;
    a_d        = a_q;
    b_d        = b_q;
    reqCount_d = reqCount_q + cnt_t'(enq) - cnt_t'(issue);
    inflight_d = inflight_q + cnt_t'(issue) - cnt_t'(capture);
    resCount_d = resCount_q + cnt_t'(capture) - cnt_t'(pop);
    issueSr_d  = {issueSr_q[LAT-1:0], issue};
    modeSr_d   = {modeSr_q[LAT-1:0], 2'b00};
    if (enq) reqWrPtr_d = reqWrPtr_q + ptr_t'(1);
    if (issue) begin
      f_d         = reqFMem[reqRdPtr_q];
      a_d         = reqAMem[reqRdPtr_q];
      b_d         = reqBMem[reqRdPtr_q];
      modeSr_d[0] = reqFMem[reqRdPtr_q];
      reqRdPtr_d  = reqRdPtr_q + ptr_t'(1);
    end
    if (capture) resWrPtr_d = resWrPtr_q + ptr_t'(1);
    if (pop) resRdPtr_d = resRdPtr_q + ptr_t'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reqWrPtr_q <= '0;
      reqRdPtr_q <= '0;
      resWrPtr_q <= '0;
      resRdPtr_q <= '0;
      reqCount_q <= '0;
      inflight_q <= '0;
      resCount_q <= '0;
      issueSr_q  <= '0;
      modeSr_q   <= '0;
      f_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      reqWrPtr_q <= reqWrPtr_d;
      reqRdPtr_q <= reqRdPtr_d;
      resWrPtr_q <= resWrPtr_d;
      resRdPtr_q <= resRdPtr_d;
      reqCount_q <= reqCount_d;
      inflight_q <= inflight_d;
      resCount_q <= resCount_d;
      issueSr_q  <= issueSr_d;
      modeSr_q   <= modeSr_d;
      f_q        <= f_d;
      a_q        <= a_d;
      b_q        <= b_d;
    end
  end

  // Queue storage is deliberately left out of reset; the counts alone define validity.
  always_ff @(posedge clk) begin
    if (enq) begin
      reqFMem[reqWrPtr_q] <= req_f_i;
      reqAMem[reqWrPtr_q] <= req_a_i;
      reqBMem[reqWrPtr_q] <= req_b_i;
    end
    if (capture) begin
      resFMem[resWrPtr_q] <= modeSr_q[LAT];
      resYMem[resWrPtr_q] <= y_i;
    end
  end

endmodule

// File: tb/tb_adder_op_queue.sv
// Bench for adder_op_queue: models the downstream adder, scoreboards every response
// against an arithmetic reference, and walks directed and randomized scenarios.
module tb_adder_op_queue;

  localparam logic [1:0] UNS  = 2'd0;
  localparam logic [1:0] ONES = 2'd1;
  localparam logic [1:0] TWOS = 2'd2;

  typedef struct {
    logic [1:0] f;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] expY;
    logic [1:0] expF;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       req_valid_i;
  logic       req_ready_o;
  logic [1:0] req_f_i;
  logic [3:0] req_a_i;
  logic [3:0] req_b_i;
  logic [1:0] f_o;
  logic [3:0] a_o;
  logic [3:0] b_o;
  logic [3:0] yModel;
  logic       rsp_valid_o;
  logic       rsp_ready_i;
  logic [3:0] rsp_y_o;
  logic [1:0] rsp_f_o;
  logic       busy_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [5:0] expQ[$];
  logic [5:0] gotQ[$];
  int         gotCyc[$];
  logic       streamDone;

  adder_op_queue #(.WIDTH(4), .DEPTH(4), .LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_f_i(req_f_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .f_o(f_o), .a_o(a_o), .b_o(b_o), .y_i(yModel),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_y_o(rsp_y_o), .rsp_f_o(rsp_f_o), .busy_o(busy_o)
  );

  function automatic logic [3:0] addRef(input logic [1:0] f, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (f == ONES) return s[3:0] + {3'b000, s[4]};
    return s[3:0];
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  // One-clock adder model: inputs sampled on an edge, sum visible right after it.
  always @(posedge clk) yModel <= addRef(f_o, a_o, b_o);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] f, input logic [3:0] a, input logic [3:0] b);
    req_valid_i = v;
    req_f_i     = f;
    req_a_i     = a;
    req_b_i     = b;
  endtask

  // Accepted requests feed the expected queue; every response pop is scored in order.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (req_valid_i && req_ready_o)
        expQ.push_back({req_f_i, addRef(req_f_i, req_a_i, req_b_i)});
      if (rsp_valid_o && rsp_ready_i) begin
        gotQ.push_back({rsp_f_o, rsp_y_o});
        gotCyc.push_back(cyc);
        if (expQ.size() == 0) begin
          checkOutput("unexpectedRsp", 32'(rsp_y_o), 32'hFFFF_FFFF);
        end else begin
          logic [5:0] e;
          e = expQ.pop_front();
          checkOutput("rspY", 32'(rsp_y_o), 32'(e[3:0]));
          checkOutput("rspF", 32'(rsp_f_o), 32'(e[5:4]));
        end
      end
    end
  end

  task automatic sendReq(input logic [1:0] f, input logic [3:0] a, input logic [3:0] b);
    int waited;
    waited = 0;
    applyStimulus(1'b1, f, a, b);
    @(negedge clk);
    while (!req_ready_o && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready_o) checkOutput("sendTimeout", 32'(req_ready_o), 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, f, a, b);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    @(negedge clk);
    while (busy_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drainBusy", 32'(busy_o), 32'd0);
    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b0;
    applyStimulus(1'b0, 2'b00, 4'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetReady", 32'(req_ready_o), 32'd1);
    checkOutput("resetRspValid", 32'(rsp_valid_o), 32'd0);
    checkOutput("resetBusy", 32'(busy_o), 32'd0);
    checkOutput("resetOperands", {22'd0, f_o, a_o, b_o}, 32'd0);
    expQ.delete();
    gotQ.delete();
    gotCyc.delete();
    rst = 1'b1;
  endtask

  initial begin
    vec_t vecs[7];
    int acc;

    rst = 1'b0;
    rsp_ready_i = 1'b1;
    streamDone = 1'b0;
    applyStimulus(1'b0, 2'b00, 4'h0, 4'h0);

    vecs[0] = '{f: UNS,  a: 4'hF, b: 4'h1, expY: 4'h0, expF: UNS};
    vecs[1] = '{f: ONES, a: 4'hF, b: 4'h1, expY: 4'h1, expF: ONES};
    vecs[2] = '{f: TWOS, a: 4'hF, b: 4'h1, expY: 4'h0, expF: TWOS};
    vecs[3] = '{f: ONES, a: 4'h7, b: 4'h1, expY: 4'h8, expF: ONES};
    vecs[4] = '{f: ONES, a: 4'hE, b: 4'hE, expY: 4'hD, expF: ONES};
    vecs[5] = '{f: UNS,  a: 4'hA, b: 4'h7, expY: 4'h1, expF: UNS};
    vecs[6] = '{f: TWOS, a: 4'h8, b: 4'h8, expY: 4'h0, expF: TWOS};

    // Single op: response must show up exactly three edges after acceptance.
    resetDut();
    rsp_ready_i = 1'b1;
    applyStimulus(1'b1, UNS, 4'hF, 4'h1);
    @(negedge clk);
    checkOutput("singleReady", 32'(req_ready_o), 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, UNS, 4'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("singleLatency", 32'(rsp_valid_o), (k == 3) ? 32'd1 : 32'd0);
      if (k < 3) @(posedge clk);
    end
    checkOutput("singleY", 32'(rsp_y_o), 32'h0);
    checkOutput("singleF", 32'(rsp_f_o), 32'(UNS));
    @(posedge clk);
    #1;
    waitDrain();

    // Table vectors streamed back to back with the consumer always ready.
    resetDut();
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) sendReq(vecs[i].f, vecs[i].a, vecs[i].b);
    waitDrain();
    checkOutput("tableCount", 32'(gotQ.size()), 32'd7);
    for (int i = 0; i < 7 && i < gotQ.size(); i++) begin
      checkOutput($sformatf("tableY%0d", i), 32'(gotQ[i][3:0]), 32'(vecs[i].expY));
      checkOutput($sformatf("tableF%0d", i), 32'(gotQ[i][5:4]), 32'(vecs[i].expF));
      if (i > 0) checkOutput($sformatf("tableGap%0d", i), 32'(gotCyc[i] - gotCyc[i-1]), 32'd1);
    end

    // Backpressure: eight requests fit, then issue stalls and operands freeze.
    resetDut();
    rsp_ready_i = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, UNS, 4'(i), 4'd3);
      @(negedge clk);
      if (req_ready_o) acc++;
      @(posedge clk);
      #1;
    end
    applyStimulus(1'b0, UNS, 4'h0, 4'h0);
    checkOutput("bpAccepted", 32'(acc), 32'd8);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("bpReadyLow", 32'(req_ready_o), 32'd0);
    checkOutput("bpHoldA", 32'(a_o), 32'd3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("bpStableA", 32'(a_o), 32'd3);
    checkOutput("bpStableFB", {28'd0, f_o, b_o[1:0]}, 32'(2'b11));
    checkOutput("bpBusy", 32'(busy_o), 32'd1);

    // Release while a request waits at a full request queue.
    @(posedge clk);
    #1;
    applyStimulus(1'b1, TWOS, 4'h9, 4'h9);
    rsp_ready_i = 1'b1;
    @(negedge clk);
    checkOutput("fullNoEnq0", 32'(req_ready_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("fullNoEnq1", 32'(req_ready_o), 32'd0);
    checkOutput("fullPreIssueA", 32'(a_o), 32'd3);
    @(posedge clk);
    @(negedge clk);
    checkOutput("fullReadyAfterIssue", 32'(req_ready_o), 32'd1);
    checkOutput("fullIssuedA", 32'(a_o), 32'd4);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, UNS, 4'h0, 4'h0);
    waitDrain();
    checkOutput("bpDrainCount", 32'(gotQ.size()), 32'd9);

    // Wrap-around with a consumer that toggles every other cycle.
    resetDut();
    rsp_ready_i = 1'b1;
    streamDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) sendReq(UNS, 4'(i), 4'd1);
        streamDone = 1'b1;
      end
      begin
        while (!streamDone) begin
          repeat (2) @(posedge clk);
          #1;
          rsp_ready_i = ~rsp_ready_i;
        end
      end
    join
    rsp_ready_i = 1'b1;
    waitDrain();
    checkOutput("wrapCount", 32'(gotQ.size()), 32'd20);
    for (int i = 0; i < 20 && i < gotQ.size(); i++)
      checkOutput($sformatf("wrapY%0d", i), 32'(gotQ[i][3:0]), 32'((i + 1) % 16));

    // Randomized traffic and consumer stalls against the scoreboard.
    resetDut();
    streamDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end else begin
            sendReq(2'($urandom_range(0, 2)), 4'($urandom), 4'($urandom));
          end
        end
        streamDone = 1'b1;
      end
      begin
        while (!streamDone) begin
          @(posedge clk);
          #1;
          rsp_ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    rsp_ready_i = 1'b1;
    waitDrain();

    // Reset with two requests queued and one in flight.
    resetDut();
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) sendReq(UNS, 4'(i + 1), 4'd2);
    repeat (6) @(posedge clk);
    #1;
    sendReq(UNS, 4'd5, 4'd6);
    sendReq(UNS, 4'd5, 4'd7);
    sendReq(UNS, 4'd5, 4'd8);
    checkOutput("preResetA", 32'(a_o), 32'd5);
    checkOutput("preResetBusy", 32'(busy_o), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("midResetRspValid", 32'(rsp_valid_o), 32'd0);
    checkOutput("midResetBusy", 32'(busy_o), 32'd0);
    checkOutput("midResetOperands", {22'd0, f_o, a_o, b_o}, 32'd0);
    expQ.delete();
    gotQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    checkOutput("postResetReady", 32'(req_ready_o), 32'd1);
    for (int k = 0; k < 5; k++) begin
      checkOutput("noStaleResult", 32'(rsp_valid_o), 32'd0);
      @(negedge clk);
    end
    checkOutput("postResetBusy", 32'(busy_o), 32'd0);
    checkOutput("postResetNoPops", 32'(gotQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
